seg7_scan_display: RTL

Parametrised time-multiplexed 7-segment display driver. It is the next-generation replacement for the fixed 4-digit hex scanner used to show I2C register address and data. It adds:
- N digits, each showing one hex nibble.
- A per-digit decimal-point mask and leading-zero suppression.
- PWM brightness control.
- Frame-synchronous data snapshot, so the display never shows a mix of old and new values.
- One dead-time cycle between digits to suppress ghosting.
It sits between the I2C master/slave status logic and the board's anode/segment pins.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/hex7seg.sv | 11 +
 rtl/seg7_scan_display.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the scanned 7-segment display driver.
package seg7_pkg;

    // Supported digit-count range.
    localparam int unsigned DIG_MIN = 2;
    localparam int unsigned DIG_MAX = 8;

    // Active-high gfedcba glyphs, indexed by nibble value (entry 0 is the rightmost).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Clocks spent on each digit.
    function automatic int unsigned calc_div(input int unsigned fclk_khz,
                                             input int unsigned fdwell_khz);
        return fclk_khz / fdwell_khz;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-high gfedcba decoder.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit hex display with frame snapshot, LZ blanking, PWM and dead time.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIG      = 4,
    parameter int unsigned FCLK_KHZ   = 50000,
    parameter int unsigned FDWELL_KHZ = 1,
    parameter int unsigned PWM_BITS   = 4,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIG-1:0]    dat,
    input  logic [N_DIG-1:0]      dp_mask,
    input  logic                  lz_en,
    input  logic                  en,
    input  logic [PWM_BITS-1:0]   bright,
    output logic [N_DIG-1:0]      AN,
    output logic [6:0]            seg,
    output logic                  seg_P,
    output logic                  frame_tick
);

    localparam int unsigned DIV   = calc_div(FCLK_KHZ, FDWELL_KHZ);
    localparam int unsigned PRE_W = $clog2(DIV);
    localparam int unsigned PTR_W = $clog2(N_DIG);
    localparam logic        POL   = (ACTIVE_LOW != 32'd0);

    // Elaboration-time parameter sanity.
    if (N_DIG < DIG_MIN || N_DIG > DIG_MAX) begin : g_bad_ndig
        $error("seg7_scan_display: N_DIG out of range");
    end
    if (DIV < 2) begin : g_bad_div
        $error("seg7_scan_display: DIV must be at least 2");
    end

    logic [PRE_W-1:0]    pre_q,  pre_d;
    logic [PTR_W-1:0]    ptr_q,  ptr_d;
    logic [PWM_BITS-1:0] pwm_q,  pwm_d;
    logic [4*N_DIG-1:0]  sdat_q, sdat_d;
    logic [N_DIG-1:0]    sdp_q,  sdp_d;
    logic                dead_q, dead_d;
    logic [N_DIG-1:0]    an_q,   an_d;
    logic [6:0]          seg_q,  seg_d;
    logic                dp_q,   dp_d;
    logic                ft_q,   ft_d;

    logic                ce_c;
    logic                wrap_c;
    logic [3:0]          nib_c;
    logic                dpsel_c;
    logic [N_DIG-1:0]    sel_c;
    logic                nz_c;
    logic                supp_c;
    logic                on_c;
    logic [6:0]          dec_c;

    // Glyph for the currently selected shadow nibble.
    hex7seg u_dec (
        .nib_i (nib_c),
        .seg_o (dec_c)
    );

    // Next-state for scan counters, snapshot and registered pin drive.
    always_comb begin
        pre_d   = pre_q;
        ptr_d   = ptr_q;
        pwm_d   = pwm_q + PWM_BITS'(1);
        sdat_d  = sdat_q;
        sdp_d   = sdp_q;
        dead_d  = 1'b0;
        ft_d    = 1'b0;
        nib_c   = 4'h0;
        dpsel_c = 1'b0;
        sel_c   = '0;
        nz_c    = 1'b0;

        ce_c   = (pre_q == PRE_W'(DIV - 1));
        wrap_c = (ptr_q == PTR_W'(N_DIG - 1));

        pre_d = ce_c ? '0 : pre_q + PRE_W'(1);
        if (ce_c) begin
            ptr_d  = wrap_c ? '0 : ptr_q + PTR_W'(1);
            dead_d = 1'b1;
            if (wrap_c) begin
                sdat_d = dat;
                sdp_d  = dp_mask;
                ft_d   = 1'b1;
            end
        end

        // Select current digit and detect any nonzero nibble at or above it.
        for (int j = 0; j < int'(N_DIG); j++) begin
            if (PTR_W'(j) == ptr_q) begin
                nib_c    = sdat_q[4*j +: 4];
                dpsel_c  = sdp_q[j];
                sel_c[j] = 1'b1;
            end
            if (PTR_W'(j) >= ptr_q && sdat_q[4*j +: 4] != 4'h0) begin
                nz_c = 1'b1;
            end
        end

        supp_c = lz_en && (ptr_q != '0) && !nz_c;
        on_c   = en && !dead_q && (pwm_q <= bright) && !supp_c;

        an_d  = (on_c ? sel_c : '0) ^ {N_DIG{POL}};
        seg_d = dec_c ^ {7{POL}};
        dp_d  = dpsel_c ^ POL;
    end

    // State and output registers with synchronous reset to inactive levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            ptr_q  <= '0;
            pwm_q  <= '0;
            sdat_q <= '0;
            sdp_q  <= '0;
            dead_q <= 1'b0;
            an_q   <= {N_DIG{POL}};
            seg_q  <= {7{POL}};
            dp_q   <= POL;
            ft_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            ptr_q  <= ptr_d;
            pwm_q  <= pwm_d;
            sdat_q <= sdat_d;
            sdp_q  <= sdp_d;
            dead_q <= dead_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            ft_q   <= ft_d;
        end
    end

    assign AN         = an_q;
    assign seg        = seg_q;
    assign seg_P      = dp_q;
    assign frame_tick = ft_q;

endmodule
